// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential ALU.
//   op_e      : 3-bit operation encoding seen on the op port
//   state_e   : control FSM states of seq_alu
//   FLAG_*    : bit positions inside the 4-bit flags bundle {carry, overflow, negative, zero}
//   pack_flags: assembles the flags bundle from its four components
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 0;

    function automatic logic [3:0] pack_flags(input logic carry, input logic ovf,
                                              input logic neg, input logic zero);
        logic [3:0] f;
        f             = '0;
        f[FLAG_CARRY] = carry;
        f[FLAG_OVF]   = ovf;
        f[FLAG_NEG]   = neg;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : load a/b and begin a new multiplication (pulse)
//   a, b            : WIDTH-bit unsigned operands, sampled on start
//   done            : product valid; stays high until the next start
//   product_lo/hi   : low / high halves of the 2*WIDTH-bit product
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left each step
    logic [2*WIDTH-1:0] acc_q;     // running partial-product sum
    logic [WIDTH-1:0]   mplier_q;  // multiplier, LSB selects the current step
    logic [CW-1:0]      cnt_q;     // steps completed
    logic               active_q;

    assign done       = active_q && (cnt_q == CW'(WIDTH));
    assign product_lo = acc_q[WIDTH-1:0];
    assign product_hi = acc_q[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q && !done) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu -- valid/ready ALU; single-cycle ops finish in one cycle, MUL runs
// through alu_mul_seq and finishes WIDTH+1 cycles after acceptance.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake for {a, b, op}
//   a, b, op              : operands and operation select (see alu_pkg::op_e)
//   out_valid / out_ready : output handshake for {result, result_hi, flags}
//   result, result_hi     : result (MUL low/high halves; result_hi is 0 otherwise)
//   flags                 : {carry, overflow, negative, zero}
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic [3:0]       flags_q;

    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_ext;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;

    // A finished result may be handed off and replaced on the same edge.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op_e'(op) == OP_MUL);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept && is_mul),
        .a          (a),
        .b          (b),
        .done       (mul_done),
        .product_lo (mul_lo),
        .product_hi (mul_hi)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};   // diff[WIDTH] is the borrow
        shamt     = b[SW-1:0];
        shl_ext   = {1'b0, a} << shamt;      // bit WIDTH holds the last bit shifted out
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOT: alu_res = ~a;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = (shamt != '0) && shl_ext[WIDTH];
            end
            default: ;                        // MUL results come from u_mul
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else if (accept) begin
            if (is_mul) begin
                state_q <= ST_BUSY;
            end else begin
                state_q     <= ST_DONE;
                result_q    <= alu_res;
                result_hi_q <= '0;
                flags_q     <= pack_flags(alu_carry, alu_ovf, alu_res[WIDTH-1], alu_res == '0);
            end
        end else if ((state_q == ST_DONE) && out_ready) begin
            state_q <= ST_IDLE;
        end else if ((state_q == ST_BUSY) && mul_done) begin
            state_q     <= ST_DONE;
            result_q    <= mul_lo;
            result_hi_q <= mul_hi;
            flags_q     <= pack_flags(mul_hi != '0, mul_hi != '0, mul_hi[WIDTH-1], mul_lo == '0);
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- scoreboard bench for seq_alu at WIDTH=8. Expected bundles
// {result_hi, result, flags} are pushed when an operation is driven and popped
// when the DUT presents its result.
module tb_seq_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] r;
        logic [3:0] f;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [3:0] flags;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written with integer arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int         ux, uy, sx, sy, t, st, sh;
        logic       c, v, n, z;
        logic [7:0] r, hi;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        c  = 1'b0;
        v  = 1'b0;
        hi = 8'h00;
        r  = 8'h00;
        t  = 0;
        case (o)
            3'd0: begin
                t = ux + uy; r = t[7:0]; c = (t > 255);
                st = sx + sy; v = (st > 127) || (st < -128);
            end
            3'd1: begin
                t = ux - uy; r = t[7:0]; c = (ux < uy);
                st = sx - sy; v = (st > 127) || (st < -128);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = ~x;
            3'd5: r = x ^ y;
            3'd6: begin
                sh = uy % 8;
                t  = ux << sh;
                r  = t[7:0];
                c  = (sh != 0) ? x[8 - sh] : 1'b0;
            end
            default: begin
                t = ux * uy; r = t[7:0]; hi = t[15:8];
                c = (hi != 8'h00); v = c;
            end
        endcase
        n = (o == 3'd7) ? hi[7] : r[7];
        z = (r == 8'h00);
        return {hi, r, c, v, n, z};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_valid, result, result_hi, flags} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, result, result_hi, flags});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_add_sub();
        op_e        t_op [3] = '{OP_ADD, OP_SUB, OP_SUB};
        logic [7:0] t_a  [3] = '{8'd200, 8'd5, 8'h80};
        logic [7:0] t_b  [3] = '{8'd100, 8'd10, 8'h01};
        exp_t       t_e  [3] = '{{8'h00, 8'd44, 4'b1000},
                                 {8'h00, 8'd251, 4'b1010},
                                 {8'h00, 8'h7F, 4'b0100}};
        exp_t       e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = t_op[i]; a = t_a[i]; b = t_b[i]; in_valid = 1'b1; out_ready = 1'b1;
            sb.push_back(t_e[i]);
            @(negedge clk);
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL add_sub_latency[%0d]: out_valid=%b expected 1", i, out_valid);
            end
            e = sb.pop_front();
            vectors++;
            if ({result_hi, result, flags} !== e) begin
                miscompares++;
                $display("FAIL add_sub[%0d]: got %h expected %h", i, {result_hi, result, flags}, e);
            end
        end
    endtask

    task automatic test_mul();
        exp_t e;
        @(negedge clk);
        op = OP_MUL; a = 8'd200; b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_accept: in_ready=%b expected 1", in_ready);
        end
        sb.push_back({8'h02, 8'h58, 4'b1100});
        @(negedge clk);
        // A bundle offered while busy must be ignored.
        op = OP_ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mul_busy[%0d]: in_ready=%b out_valid=%b expected 0/0", k, in_ready, out_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_early: out_valid=%b expected 0 at 8 cycles", out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_latency: out_valid=%b expected 1 at 9 cycles", out_valid);
        end
        e = sb.pop_front();
        vectors++;
        if ({result_hi, result, flags} !== e) begin
            miscompares++;
            $display("FAIL mul_result: got %h expected %h", {result_hi, result, flags}, e);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_ghost: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_pressure();
        exp_t e;
        @(negedge clk);
        op = OP_ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1; out_ready = 1'b0;
        sb.push_back({8'h00, 8'h02, 4'b0000});
        @(negedge clk);
        op = OP_XOR; a = 8'hF0; b = 8'hFF;   // held while the stall lasts
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || {result_hi, result, flags} !== e || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h in_ready=%b expected 1/%h/0",
                         k, out_valid, {result_hi, result, flags}, e, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%b expected 1", in_ready);
        end
        sb.push_back({8'h00, 8'h0F, 4'b0000});
        @(negedge clk);
        in_valid = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || {result_hi, result, flags} !== e) begin
            miscompares++;
            $display("FAIL bp_xor: valid=%b data=%h expected 1/%h", out_valid, {result_hi, result, flags}, e);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_stream();
        op_e        t_op [4] = '{OP_AND, OP_OR, OP_NOT, OP_SHL};
        logic [7:0] t_a  [4] = '{8'hCC, 8'hCC, 8'hCC, 8'h81};
        logic [7:0] t_b  [4] = '{8'hAA, 8'hAA, 8'h55, 8'h01};
        exp_t       t_e  [4] = '{{8'h00, 8'h88, 4'b0010},
                                 {8'h00, 8'hEE, 4'b0010},
                                 {8'h00, 8'h33, 4'b0000},
                                 {8'h00, 8'h02, 4'b1000}};
        exp_t       e;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                e = sb.pop_front();
                vectors++;
                if (out_valid !== 1'b1 || {result_hi, result, flags} !== e) begin
                    miscompares++;
                    $display("FAIL stream[%0d]: valid=%b data=%h expected 1/%h",
                             i - 1, out_valid, {result_hi, result, flags}, e);
                end
            end
            if (i < 4) begin
                op = t_op[i]; a = t_a[i]; b = t_b[i]; in_valid = 1'b1;
                sb.push_back(t_e[i]);
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_ready[%0d]: in_ready=%b expected 1", i, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        @(negedge clk);
        op = OP_MUL; a = 8'd200; b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, result, result_hi, flags} !== 21'd0) begin
            miscompares++;
            $display("FAIL mid_mul_reset: got %h expected 0", {out_valid, result, result_hi, flags});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_mul_ready: in_ready=%b expected 1", in_ready);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL mid_mul_stale: %0d result cycles seen expected 0", seen);
        end
    endtask

    task automatic test_random();
        int   issued;
        int   cycles;
        logic fired;
        exp_t e;
        issued   = 0;
        cycles   = 0;
        fired    = 1'b0;
        in_valid = 1'b0;
        while ((issued < 30 || sb.size() != 0) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (fired) in_valid = 1'b0;
            fired = 1'b0;
            if (!in_valid && issued < 30 && $urandom_range(0, 3) != 0) begin
                op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL random_unexpected: data=%h with empty scoreboard", {result_hi, result, flags});
                end else begin
                    e = sb.pop_front();
                    if ({result_hi, result, flags} !== e) begin
                        miscompares++;
                        $display("FAIL random: got %h expected %h", {result_hi, result, flags}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(op, a, b));
                issued++;
                fired = 1'b1;
            end
        end
        vectors++;
        if (issued < 30 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL random_timeout: issued=%0d pending=%0d expected 30/0", issued, sb.size());
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = 8'h00;
        b           = 8'h00;
        op          = 3'd0;
        test_reset();
        test_add_sub();
        test_mul();
        test_back_pressure();
        test_stream();
        test_reset_mid_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
